mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences and shares the single-port 64-bit BIOS/RAM word memory between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Each requester sees a valid/ready request and a valid/ready response; the block drives the memory's addr/data/mask/shift/rw/enable pins.
- One transaction is in flight at a time. The LSU has priority, and a run-length limit prevents IFU starvation.
- The top level builds the memory's inout data bus as: data = mem_rw ? mem_wdata : 'z; mem_rdata = data.

Parameters:
- ADDR_W, 11, word address width; maps to memory addr[13:3].
- DATA_W, 64, word width. Mask width is DATA_W/8.
- MAX_LSU_RUN, 4, maximum consecutive LSU grants while the IFU is waiting. Range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  ADDR_W  IFU word address
- ifu_rsp_valid  out  1  IFU read data valid on rsp_rdata
- ifu_rsp_ready  in  1  IFU takes the response
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  ADDR_W  LSU word address
- lsu_req_rw  in  1  1 = write, 0 = read
- lsu_req_wdata  in  DATA_W  write data, before shift
- lsu_req_mask  in  8  byte-lane write enables
- lsu_req_shift  in  6  left-shift amount applied by the memory
- lsu_rsp_valid  out  1  LSU response: read data, or write acknowledge
- lsu_rsp_ready  in  1  LSU takes the response
- rsp_rdata  out  DATA_W  read data shared by both responders; qualified by the *_rsp_valid signals
- mem_en  out  1  memory enable
- mem_rw  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_mask  out  8  memory byte mask
- mem_shift  out  6  memory shift
- mem_rdata  in  DATA_W  memory read bus; valid only while mem_en=1 and mem_rw=0

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - All *_valid, *_ready, mem_en and mem_rw outputs = 0.
  - mem_addr, mem_wdata, mem_mask, mem_shift, rsp_rdata and run counter = 0.
  - A write in flight is dropped. mem_en falls during reset, so memory is never written while rst=1.
- Memory contract:
  - An enabled read edge loads the memory's output register.
  - Data is on mem_rdata only while mem_en=1 and mem_rw=0.
  - An enabled write edge commits masked bytes of (wdata << shift).
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE:
  - Winner selection: the LSU wins if lsu_req_valid, unless ifu_req_valid and run counter == MAX_LSU_RUN; otherwise the IFU wins if ifu_req_valid.
  - The winner's *_req_ready = 1 (combinational); the loser's ready = 0.
  - On the accept edge: latch owner, addr, rw (IFU: rw=0), wdata, mask, shift into the mem_* registers; go to ACCESS.
  - Run counter:
    - LSU grant while ifu_req_valid: increment, saturating at MAX_LSU_RUN.
    - IFU grant, or LSU grant with ifu_req_valid=0: clear to 0.
- ACCESS:
  - mem_en=1, mem_rw = latched rw. Exactly one cycle.
  - Write: go to RESP.
  - Read: go to CAPTURE.
- CAPTURE (read only):
  - mem_en=1, mem_rw=0, same address.
  - Register mem_rdata into rsp_rdata at the end of this cycle; go to RESP.
- RESP:
  - mem_en=0. The owner's *_rsp_valid=1; rsp_rdata is stable.
  - Held until the owner's *_rsp_ready=1. On that edge go to IDLE; a new accept is possible the following cycle.
  - For writes, rsp_rdata keeps its previous value (acknowledge only).
- Latency, accept edge to rsp_valid high:
  - Read: 3 cycles.
  - Write: 2 cycles.
  - Back-to-back throughput: 1 transaction per 4 (read) / 3 (write) cycles with rsp_ready tied high.
- Request inputs are sampled only on the accept edge; later changes are ignored.
- Both *_req_ready outputs are 0 in every state except IDLE.
- rsp_valid is never asserted for the non-owner.

Optional Feature:
- MEM_ARB_STATS_EN defined:
  - Adds output ports ifu_grant_cnt and lsu_grant_cnt, 32 bits each.
  - Each increments on every accept edge for its requester, wraps at 2^32, and resets to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- LSU write addr 0x010, wdata 0x1122334455667788, mask 0xFF, shift 0; then LSU read 0x010 -> lsu_rsp_valid 3 cycles after accept, rsp_rdata = 0x1122334455667788; mem_en high exactly 1 cycle for the write, 2 for the read.
- Over word 0x010: LSU write wdata 0xAB, mask 0x04, shift 16; IFU read 0x010 -> rsp_rdata = 0x1122334455AB7788, ifu_rsp_valid only.
- MAX_LSU_RUN=2, both requesters continuously valid, rsp_ready=1 -> grant order LSU, LSU, IFU, LSU, LSU, IFU.
- LSU read with lsu_rsp_ready low for 5 cycles -> lsu_rsp_valid and rsp_rdata held, both req_ready=0, mem_en=0 throughout; IFU accepted the cycle after release.
- rst pulsed while in ACCESS of write 0xFFFF...FF to 0x010 -> mem_en=0 within the same cycle, all outputs at reset values, readback returns the prior 0x1122334455AB7788.
- With MEM_ARB_STATS_EN: 3 IFU + 5 LSU transactions -> ifu_grant_cnt=3, lsu_grant_cnt=5; both 0 after rst.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles every handshake and memory-pin signal of mem_arbiter.
//
// Parameters:
//   ADDR_W  word address width
//   DATA_W  word width (mask is DATA_W/8 bits, shift is log2(DATA_W) bits)
//
// Signal groups:
//   ifu_req_*  / ifu_rsp_*   IFU read request and read response
//   lsu_req_*  / lsu_rsp_*   LSU read/write request and response
//   rsp_rdata                read data shared by both responders
//   mem_*                    single-port word memory pins
//
// Modports:
//   slave   the arbiter side (requests/mem_rdata in, grants/responses/pins out)
//   master  the requesters plus memory side (the mirror image)
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 64
);
   localparam int MASK_W  = DATA_W / 8;
   localparam int SHIFT_W = $clog2(DATA_W);

   logic                ifu_req_valid;
   logic                ifu_req_ready;
   logic [ADDR_W-1:0]   ifu_req_addr;
   logic                ifu_rsp_valid;
   logic                ifu_rsp_ready;

   logic                lsu_req_valid;
   logic                lsu_req_ready;
   logic [ADDR_W-1:0]   lsu_req_addr;
   logic                lsu_req_rw;
   logic [DATA_W-1:0]   lsu_req_wdata;
   logic [MASK_W-1:0]   lsu_req_mask;
   logic [SHIFT_W-1:0]  lsu_req_shift;
   logic                lsu_rsp_valid;
   logic                lsu_rsp_ready;

   logic [DATA_W-1:0]   rsp_rdata;

   logic                mem_en;
   logic                mem_rw;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [MASK_W-1:0]   mem_mask;
   logic [SHIFT_W-1:0]  mem_shift;
   logic [DATA_W-1:0]   mem_rdata;

   modport slave (
      input  ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
      input  lsu_req_valid, lsu_req_addr, lsu_req_rw, lsu_req_wdata,
      input  lsu_req_mask, lsu_req_shift, lsu_rsp_ready,
      input  mem_rdata,
      output ifu_req_ready, ifu_rsp_valid,
      output lsu_req_ready, lsu_rsp_valid,
      output rsp_rdata,
      output mem_en, mem_rw, mem_addr, mem_wdata, mem_mask, mem_shift
   );

   modport master (
      output ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
      output lsu_req_valid, lsu_req_addr, lsu_req_rw, lsu_req_wdata,
      output lsu_req_mask, lsu_req_shift, lsu_rsp_ready,
      output mem_rdata,
      input  ifu_req_ready, ifu_rsp_valid,
      input  lsu_req_ready, lsu_rsp_valid,
      input  rsp_rdata,
      input  mem_en, mem_rw, mem_addr, mem_wdata, mem_mask, mem_shift
   );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port word memory between the IFU (read only) and the LSU
// (read/write). One transaction is in flight at a time; the LSU has priority,
// but after MAX_LSU_RUN consecutive LSU grants with the IFU waiting, the IFU
// is served next.
//
// Transaction shape (one cycle each):
//   IDLE (accept) -> ACCESS -> [CAPTURE, reads only] -> RESP (until rsp_ready)
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   bus (slave)    IFU/LSU request+response handshakes, shared rsp_rdata and
//                  the memory pins mem_en/rw/addr/wdata/mask/shift/rdata
//   ifu_grant_cnt  (MEM_ARB_STATS_EN only) IFU accepts, wraps at 2^32
//   lsu_grant_cnt  (MEM_ARB_STATS_EN only) LSU accepts, wraps at 2^32
//
// Build option:
//   MEM_ARB_STATS_EN  adds the two grant counters and their output ports.
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W      = 11,
   parameter int DATA_W      = 64,
   parameter int MAX_LSU_RUN = 4
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [31:0]   ifu_grant_cnt,
   output logic [31:0]   lsu_grant_cnt
`endif
);

   localparam int         MASK_W  = DATA_W / 8;
   localparam int         SHIFT_W = $clog2(DATA_W);
   localparam logic [3:0] RUN_MAX = 4'(MAX_LSU_RUN);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

   state_t              state_r;
   state_t              state_next_s;

   logic                owner_lsu_r;     // 1 = LSU owns the transaction
   logic                txn_rw_r;        // latched rw of the current transaction
   logic [3:0]          run_cnt_r;       // consecutive LSU grants with IFU waiting

   logic                lsu_wins_s;
   logic                grant_lsu_s;
   logic                grant_ifu_s;
   logic                rsp_done_s;

   logic                mem_en_r;
   logic                mem_rw_r;
   logic [ADDR_W-1:0]   mem_addr_r;
   logic [DATA_W-1:0]   mem_wdata_r;
   logic [MASK_W-1:0]   mem_mask_r;
   logic [SHIFT_W-1:0]  mem_shift_r;
   logic [DATA_W-1:0]   rsp_rdata_r;
   logic                ifu_rsp_valid_r;
   logic                lsu_rsp_valid_r;

   // Next-state logic, winner selection and grant strobes.
   always_comb begin
      state_next_s = state_r;
      lsu_wins_s   = 1'b0;
      grant_lsu_s  = 1'b0;
      grant_ifu_s  = 1'b0;
      rsp_done_s   = 1'b0;

      // The IFU only overrides the LSU once the LSU has used up its run.
      if (bus.lsu_req_valid && !(bus.ifu_req_valid && (run_cnt_r == RUN_MAX))) begin
         lsu_wins_s = 1'b1;
      end else begin
         lsu_wins_s = 1'b0;
      end

      if (owner_lsu_r) begin
         rsp_done_s = bus.lsu_rsp_ready;
      end else begin
         rsp_done_s = bus.ifu_rsp_ready;
      end

      case (state_r)
         ST_IDLE: begin
            // Grants are held off while rst is high so ready reads 0 in reset.
            if (rst) begin
               state_next_s = ST_IDLE;
            end else if (lsu_wins_s) begin
               grant_lsu_s  = 1'b1;
               state_next_s = ST_ACCESS;
            end else if (bus.ifu_req_valid) begin
               grant_ifu_s  = 1'b1;
               state_next_s = ST_ACCESS;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (txn_rw_r) begin
               state_next_s = ST_RESP;
            end else begin
               state_next_s = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            state_next_s = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_done_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_RESP;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Transaction capture on the accept edge: owner, rw and the memory pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_lsu_r <= 1'b0;
         txn_rw_r    <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= {DATA_W{1'b0}};
         mem_mask_r  <= {MASK_W{1'b0}};
         mem_shift_r <= {SHIFT_W{1'b0}};
      end else if (grant_lsu_s) begin
         owner_lsu_r <= 1'b1;
         txn_rw_r    <= bus.lsu_req_rw;
         mem_addr_r  <= bus.lsu_req_addr;
         mem_wdata_r <= bus.lsu_req_wdata;
         mem_mask_r  <= bus.lsu_req_mask;
         mem_shift_r <= bus.lsu_req_shift;
      end else if (grant_ifu_s) begin
         // IFU fetches are plain reads; clear the write-side pins.
         owner_lsu_r <= 1'b0;
         txn_rw_r    <= 1'b0;
         mem_addr_r  <= bus.ifu_req_addr;
         mem_wdata_r <= {DATA_W{1'b0}};
         mem_mask_r  <= {MASK_W{1'b0}};
         mem_shift_r <= {SHIFT_W{1'b0}};
      end else begin
         owner_lsu_r <= owner_lsu_r;
         txn_rw_r    <= txn_rw_r;
         mem_addr_r  <= mem_addr_r;
         mem_wdata_r <= mem_wdata_r;
         mem_mask_r  <= mem_mask_r;
         mem_shift_r <= mem_shift_r;
      end
   end

   // Registered memory strobes: enable through ACCESS (and CAPTURE for
   // reads); the write strobe only in ACCESS, which is entered only on a grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_en_r <= 1'b0;
         mem_rw_r <= 1'b0;
      end else begin
         mem_en_r <= (state_next_s == ST_ACCESS) || (state_next_s == ST_CAPTURE);
         mem_rw_r <= grant_lsu_s & bus.lsu_req_rw;
      end
   end

   // Read data is taken from the memory output register during CAPTURE;
   // writes leave the previous value in place.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_rdata_r <= {DATA_W{1'b0}};
      end else if (state_r == ST_CAPTURE) begin
         rsp_rdata_r <= bus.mem_rdata;
      end else begin
         rsp_rdata_r <= rsp_rdata_r;
      end
   end

   // Registered response valids, raised only for the owner while in RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ifu_rsp_valid_r <= 1'b0;
         lsu_rsp_valid_r <= 1'b0;
      end else begin
         ifu_rsp_valid_r <= (state_next_s == ST_RESP) && !owner_lsu_r;
         lsu_rsp_valid_r <= (state_next_s == ST_RESP) &&  owner_lsu_r;
      end
   end

   // Starvation guard: count LSU grants that bypass a waiting IFU.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_cnt_r <= 4'd0;
      end else if (grant_lsu_s && bus.ifu_req_valid) begin
         if (run_cnt_r == RUN_MAX) begin
            run_cnt_r <= run_cnt_r;
         end else begin
            run_cnt_r <= run_cnt_r + 4'd1;
         end
      end else if (grant_lsu_s || grant_ifu_s) begin
         run_cnt_r <= 4'd0;
      end else begin
         run_cnt_r <= run_cnt_r;
      end
   end

`ifdef MEM_ARB_STATS_EN
   logic [31:0] ifu_grant_cnt_r;
   logic [31:0] lsu_grant_cnt_r;

   // Free-running per-requester accept counters (wrap naturally).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ifu_grant_cnt_r <= 32'd0;
         lsu_grant_cnt_r <= 32'd0;
      end else begin
         ifu_grant_cnt_r <= ifu_grant_cnt_r + {31'd0, grant_ifu_s};
         lsu_grant_cnt_r <= lsu_grant_cnt_r + {31'd0, grant_lsu_s};
      end
   end

   assign ifu_grant_cnt = ifu_grant_cnt_r;
   assign lsu_grant_cnt = lsu_grant_cnt_r;
`endif

   assign bus.ifu_req_ready = grant_ifu_s;
   assign bus.lsu_req_ready = grant_lsu_s;
   assign bus.ifu_rsp_valid = ifu_rsp_valid_r;
   assign bus.lsu_rsp_valid = lsu_rsp_valid_r;
   assign bus.rsp_rdata     = rsp_rdata_r;
   assign bus.mem_en        = mem_en_r;
   assign bus.mem_rw        = mem_rw_r;
   assign bus.mem_addr      = mem_addr_r;
   assign bus.mem_wdata     = mem_wdata_r;
   assign bus.mem_mask      = mem_mask_r;
   assign bus.mem_shift     = mem_shift_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed, table-driven bench for mem_arbiter (built with MAX_LSU_RUN = 2)
// with a behavioural word memory behind the mem_* pins.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
   localparam int ADDR_W = 11;
   localparam int DATA_W = 64;

   logic clk = 1'b0;
   logic rst;
   logic mem_init;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic [63:0] last_exp;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef MEM_ARB_STATS_EN
   logic [31:0] ifu_grant_cnt;
   logic [31:0] lsu_grant_cnt;
`endif

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LSU_RUN(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef MEM_ARB_STATS_EN
      ,
      .ifu_grant_cnt (ifu_grant_cnt),
      .lsu_grant_cnt (lsu_grant_cnt)
`endif
   );

   // Behavioural memory: output register loaded on an enabled read edge,
   // masked bytes of (wdata << shift) committed on an enabled write edge.
   logic [63:0] mem [0:2047];
   logic [63:0] mem_out = 64'd0;
   logic [63:0] mem_shifted_s;
   logic [63:0] mem_merged_s;

   always_comb begin
      mem_shifted_s = bus.mem_wdata << bus.mem_shift;
      mem_merged_s  = mem[bus.mem_addr];
      for (int b = 0; b < 8; b++) begin
         if (bus.mem_mask[b]) mem_merged_s[b*8 +: 8] = mem_shifted_s[b*8 +: 8];
      end
   end

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 2048; i++) mem[i] <= 64'd0;
      end else if (bus.mem_en) begin
         if (bus.mem_rw) mem[bus.mem_addr] <= mem_merged_s;
         else            mem_out <= mem[bus.mem_addr];
      end
   end

   assign bus.mem_rdata = (bus.mem_en && !bus.mem_rw) ? mem_out : 64'hDEAD_BEEF_0BAD_F00D;

`ifdef MEM_ARB_STATS_EN
   int n_ifu;
   int n_lsu;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         n_ifu <= 0;
         n_lsu <= 0;
      end else begin
         if (bus.ifu_req_valid && bus.ifu_req_ready) n_ifu <= n_ifu + 1;
         if (bus.lsu_req_valid && bus.lsu_req_ready) n_lsu <= n_lsu + 1;
      end
   end
`endif

   typedef struct {
      logic        ifu_v;
      logic [10:0] ifu_addr;
      logic        lsu_v;
      logic [10:0] lsu_addr;
      logic        lsu_rw;
      logic [63:0] wdata;
      logic [7:0]  mask;
      logic [5:0]  shift;
      logic        exp_lsu;
      logic [63:0] exp_rdata;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive_idle();
      bus.ifu_req_valid = 1'b0;
      bus.ifu_req_addr  = 11'd0;
      bus.ifu_rsp_ready = 1'b1;
      bus.lsu_req_valid = 1'b0;
      bus.lsu_req_addr  = 11'd0;
      bus.lsu_req_rw    = 1'b0;
      bus.lsu_req_wdata = 64'd0;
      bus.lsu_req_mask  = 8'd0;
      bus.lsu_req_shift = 6'd0;
      bus.lsu_rsp_ready = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ifu_req_ready"}, 64'(bus.ifu_req_ready), 64'd0);
      check({tag, "_lsu_req_ready"}, 64'(bus.lsu_req_ready), 64'd0);
      check({tag, "_ifu_rsp_valid"}, 64'(bus.ifu_rsp_valid), 64'd0);
      check({tag, "_lsu_rsp_valid"}, 64'(bus.lsu_rsp_valid), 64'd0);
      check({tag, "_mem_en"},        64'(bus.mem_en), 64'd0);
      check({tag, "_mem_rw"},        64'(bus.mem_rw), 64'd0);
      check({tag, "_mem_addr"},      64'(bus.mem_addr), 64'd0);
      check({tag, "_mem_wdata"},     bus.mem_wdata, 64'd0);
      check({tag, "_mem_mask"},      64'(bus.mem_mask), 64'd0);
      check({tag, "_mem_shift"},     64'(bus.mem_shift), 64'd0);
      check({tag, "_rsp_rdata"},     bus.rsp_rdata, 64'd0);
`ifdef MEM_ARB_STATS_EN
      check({tag, "_ifu_grant_cnt"}, 64'(ifu_grant_cnt), 64'd0);
      check({tag, "_lsu_grant_cnt"}, 64'(lsu_grant_cnt), 64'd0);
`endif
   endtask

   // One complete transaction: arbitration, accept, ACCESS/CAPTURE/RESP timing.
   task automatic run_txn(input vec_t v, input int idx);
      logic        own_l;
      logic        is_wr;
      logic [10:0] exp_addr;
      logic [63:0] exp_rd;
      int          lat;
      int          men;
      string       tag;
      tag      = $sformatf("v%0d", idx);
      own_l    = v.exp_lsu;
      is_wr    = own_l & v.lsu_rw;
      exp_addr = own_l ? v.lsu_addr : v.ifu_addr;
      exp_rd   = is_wr ? last_exp : v.exp_rdata;
      @(negedge clk);
      bus.ifu_req_valid = v.ifu_v;
      bus.ifu_req_addr  = v.ifu_addr;
      bus.lsu_req_valid = v.lsu_v;
      bus.lsu_req_addr  = v.lsu_addr;
      bus.lsu_req_rw    = v.lsu_rw;
      bus.lsu_req_wdata = v.wdata;
      bus.lsu_req_mask  = v.mask;
      bus.lsu_req_shift = v.shift;
      bus.ifu_rsp_ready = 1'b1;
      bus.lsu_rsp_ready = 1'b1;
      #1;
      check({tag, "_ifu_req_ready"}, 64'(bus.ifu_req_ready), 64'(!own_l));
      check({tag, "_lsu_req_ready"}, 64'(bus.lsu_req_ready), 64'(own_l));
      @(posedge clk);
      #1;
      // Scramble the request after the accept edge; the DUT must ignore it.
      bus.ifu_req_valid = 1'b0;
      bus.lsu_req_valid = 1'b0;
      bus.ifu_req_addr  = ~v.ifu_addr;
      bus.lsu_req_addr  = ~v.lsu_addr;
      bus.lsu_req_rw    = ~v.lsu_rw;
      bus.lsu_req_wdata = ~v.wdata;
      bus.lsu_req_mask  = ~v.mask;
      bus.lsu_req_shift = ~v.shift;
      lat = 0;
      men = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (bus.mem_en) men++;
         if (k == 1) begin
            check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(exp_addr));
            check({tag, "_mem_rw"},   64'(bus.mem_rw), 64'(is_wr));
         end
         if ((own_l ? bus.lsu_rsp_valid : bus.ifu_rsp_valid) && (lat == 0)) begin
            lat = k;
            check({tag, "_rsp_rdata"}, bus.rsp_rdata, exp_rd);
         end
         check({tag, "_nonowner_rsp_valid"},
               64'(own_l ? bus.ifu_rsp_valid : bus.lsu_rsp_valid), 64'd0);
         check({tag, "_req_ready_busy"}, 64'(bus.ifu_req_ready | bus.lsu_req_ready), 64'd0);
      end
      check({tag, "_latency"},       64'(lat), is_wr ? 64'd2 : 64'd3);
      check({tag, "_mem_en_cycles"}, 64'(men), is_wr ? 64'd1 : 64'd2);
      last_exp = exp_rd;
   endtask

   logic [63:0] held;
   int          got;
   int          wcnt;
   int          prev_cyc;
   logic        exp_order [6];
   vec_t        rb;

   initial begin
      // {ifu_v, ifu_addr, lsu_v, lsu_addr, rw, wdata, mask, shift, exp_lsu, exp_rdata}
      vecs[0]  = '{1'b0, 11'h000, 1'b1, 11'h010, 1'b1, 64'h1122334455667788, 8'hFF, 6'd0,  1'b1, 64'h0};
      vecs[1]  = '{1'b0, 11'h000, 1'b1, 11'h010, 1'b0, 64'h0,                8'h00, 6'd0,  1'b1, 64'h1122334455667788};
      vecs[2]  = '{1'b0, 11'h000, 1'b1, 11'h010, 1'b1, 64'h00000000000000AB, 8'h04, 6'd16, 1'b1, 64'h0};
      vecs[3]  = '{1'b1, 11'h010, 1'b0, 11'h000, 1'b0, 64'h0,                8'h00, 6'd0,  1'b0, 64'h1122334455AB7788};
      vecs[4]  = '{1'b0, 11'h000, 1'b1, 11'h7FF, 1'b1, 64'h000000000000005A, 8'h80, 6'd56, 1'b1, 64'h0};
      vecs[5]  = '{1'b1, 11'h7FF, 1'b0, 11'h000, 1'b0, 64'h0,                8'h00, 6'd0,  1'b0, 64'h5A00000000000000};
      vecs[6]  = '{1'b0, 11'h000, 1'b1, 11'h000, 1'b1, 64'h0000000000000102, 8'hFF, 6'd56, 1'b1, 64'h0};
      vecs[7]  = '{1'b0, 11'h000, 1'b1, 11'h000, 1'b0, 64'h0,                8'h00, 6'd0,  1'b1, 64'h0200000000000000};
      vecs[8]  = '{1'b1, 11'h7FF, 1'b1, 11'h000, 1'b0, 64'h0,                8'h00, 6'd0,  1'b1, 64'h0200000000000000};
      vecs[9]  = '{1'b1, 11'h7FF, 1'b1, 11'h001, 1'b1, 64'h000000000000CAFE, 8'h03, 6'd0,  1'b1, 64'h0};
      vecs[10] = '{1'b1, 11'h7FF, 1'b1, 11'h001, 1'b0, 64'h0,                8'h00, 6'd0,  1'b0, 64'h5A00000000000000};
      vecs[11] = '{1'b0, 11'h000, 1'b1, 11'h001, 1'b0, 64'h0,                8'h00, 6'd0,  1'b1, 64'h000000000000CAFE};
      exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

      // Reset and memory clear.
      rst      = 1'b1;
      mem_init = 1'b1;
      last_exp = 64'd0;
      drive_idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst      = 1'b0;
      mem_init = 1'b0;

      // Table-driven transactions.
      for (int i = 0; i < 12; i++) run_txn(vecs[i], i);

      // Reset pulsed in the ACCESS cycle of a full-ones write to word 0x010.
      @(negedge clk);
      bus.lsu_req_valid = 1'b1;
      bus.lsu_req_addr  = 11'h010;
      bus.lsu_req_rw    = 1'b1;
      bus.lsu_req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.lsu_req_mask  = 8'hFF;
      bus.lsu_req_shift = 6'd0;
      @(posedge clk);
      #1;
      bus.lsu_req_valid = 1'b0;
      check("rst_pre_mem_en", 64'(bus.mem_en), 64'd1);
      #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_access");
      @(posedge clk);
      @(negedge clk);
      rst      = 1'b0;
      last_exp = 64'd0;
      rb = '{1'b1, 11'h010, 1'b0, 11'h000, 1'b0, 64'h0, 8'h00, 6'd0, 1'b0, 64'h1122334455AB7788};
      run_txn(rb, 100);

      // Both requesters continuously valid: L, L, I, L, L, I at one accept per 4 cycles.
      @(negedge clk);
      bus.ifu_req_valid = 1'b1;
      bus.ifu_req_addr  = 11'h010;
      bus.lsu_req_valid = 1'b1;
      bus.lsu_req_addr  = 11'h001;
      bus.lsu_req_rw    = 1'b0;
      bus.ifu_rsp_ready = 1'b1;
      bus.lsu_rsp_ready = 1'b1;
      prev_cyc = 0;
      for (int n = 0; n < 6; n++) begin
         got  = 2;
         wcnt = 0;
         #1;
         while ((got == 2) && (wcnt < 20)) begin
            if (bus.lsu_req_ready)      got = 1;
            else if (bus.ifu_req_ready) got = 0;
            else begin
               @(negedge clk);
               #1;
               wcnt++;
            end
         end
         check($sformatf("grant_order_%0d", n), 64'(got), 64'(exp_order[n]));
         if (n > 0) check($sformatf("grant_gap_%0d", n), 64'(cyc - prev_cyc), 64'd4);
         prev_cyc = cyc;
         @(posedge clk);
         if (n == 5) begin
            #1;
            bus.ifu_req_valid = 1'b0;
            bus.lsu_req_valid = 1'b0;
         end
         @(negedge clk);
      end
      repeat (5) @(negedge clk);

      // LSU read held in RESP by lsu_rsp_ready low; IFU waiting throughout.
      bus.ifu_req_valid = 1'b1;
      bus.ifu_req_addr  = 11'h7FF;
      bus.lsu_req_valid = 1'b1;
      bus.lsu_req_addr  = 11'h010;
      bus.lsu_req_rw    = 1'b0;
      bus.lsu_rsp_ready = 1'b0;
      bus.ifu_rsp_ready = 1'b1;
      #1;
      check("bp_lsu_req_ready", 64'(bus.lsu_req_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.lsu_req_valid = 1'b0;
      wcnt = 0;
      @(negedge clk);
      while (!bus.lsu_rsp_valid && (wcnt < 10)) begin
         @(negedge clk);
         wcnt++;
      end
      check("bp_rsp_wait", 64'(wcnt), 64'd2);
      held = bus.rsp_rdata;
      check("bp_rsp_rdata", held, 64'h1122334455AB7788);
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk);
         check("bp_lsu_rsp_valid", 64'(bus.lsu_rsp_valid), 64'd1);
         check("bp_rdata_stable",  bus.rsp_rdata, 64'h1122334455AB7788);
         check("bp_req_ready",     64'(bus.ifu_req_ready | bus.lsu_req_ready), 64'd0);
         check("bp_mem_en",        64'(bus.mem_en), 64'd0);
         check("bp_ifu_rsp_valid", 64'(bus.ifu_rsp_valid), 64'd0);
      end
      bus.lsu_rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      check("bp_ifu_accept_next", 64'(bus.ifu_req_ready), 64'd1);
      check("bp_lsu_rsp_dropped", 64'(bus.lsu_rsp_valid), 64'd0);
      @(posedge clk);
      #1;
      bus.ifu_req_valid = 1'b0;
      wcnt = 0;
      @(negedge clk);
      while (!bus.ifu_rsp_valid && (wcnt < 10)) begin
         @(negedge clk);
         wcnt++;
      end
      check("bp_ifu_rsp_wait",  64'(wcnt), 64'd2);
      check("bp_ifu_rsp_rdata", bus.rsp_rdata, 64'h5A00000000000000);
      repeat (3) @(negedge clk);

`ifdef MEM_ARB_STATS_EN
      check("stats_ifu", 64'(ifu_grant_cnt), 64'(n_ifu));
      check("stats_lsu", 64'(lsu_grant_cnt), 64'(n_lsu));
      check("stats_ifu_seen", 64'(n_ifu > 0), 64'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
